// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter for two requesters in front of a word-only data memory.
// Sub-word stores become a read-modify-write pair. Each response is a one-cycle registered pulse.
// Ports: clk, rst_n (async, active-low);
//   reqN_valid/ready/we/size/addr/wdata carry requests from requester N (N = 0, 1);
//   reqN_rvalid/rdata/err return the response to requester N;
//   mem_we/mem_a/mem_wd drive the memory, and mem_rd is its combinational read data.
// ready and mem_* are combinational because the memory read and the accept share one cycle.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [1:0]            req0_size,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_wdata,
  output logic                  req0_rvalid,
  output logic [31:0]           req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [1:0]            req1_size,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_wdata,
  output logic                  req1_rvalid,
  output logic [31:0]           req1_rdata,
  output logic                  req1_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state_q, state_d;
  logic                  last_q, owner_q, sel, any_v;
  logic [31:0]           merge_q;
  logic                  accept, latch;
  logic                  s_we, mis;
  logic [1:0]            s_size;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [31:0]           s_wdata;
  logic [4:0]            sh;
  logic [31:0]           load_data, lane_mask, merged, rsp_data_c;

  // Grant selection: in RMW_WR the owner keeps the grant, otherwise round-robin on contention.
  always_comb begin
    sel   = owner_q;
    any_v = 1'b0;
    if (state_q == IDLE) begin
      any_v = req0_valid | req1_valid;
      if (req0_valid && req1_valid) sel = ~last_q;
      else                          sel = req1_valid;
    end
    s_we    = sel ? req1_we    : req0_we;
    s_size  = sel ? req1_size  : req0_size;
    s_addr  = sel ? req1_addr  : req0_addr;
    s_wdata = sel ? req1_wdata : req0_wdata;
  end

  // Alignment check, load lane extraction and store lane merge.
  always_comb begin
    mis = ((s_size == 2'b01) && s_addr[0]) || (s_size[1] && (s_addr[1:0] != 2'b00));
    sh  = {s_addr[1:0], 3'b000};
    case (s_size)
      2'b00:   load_data = (mem_rd >> sh) & 32'h0000_00FF;
      2'b01:   load_data = (mem_rd >> sh) & 32'h0000_FFFF;
      default: load_data = mem_rd;
    endcase
    lane_mask  = ((s_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged     = (merge_q & ~lane_mask) | ((s_wdata << sh) & lane_mask);
    rsp_data_c = (!mis && !s_we) ? load_data : 32'h0;
  end

  // Next state and memory/ready controls; everything is held at zero while reset is asserted.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    latch   = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = 32'h0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (any_v) begin
            mem_a = {s_addr[ADDR_WIDTH-1:2], 2'b00};
            if (mis || !s_we) begin
              accept = 1'b1;
            end else if (s_size[1]) begin
              mem_we = 1'b1;
              mem_wd = s_wdata;
              accept = 1'b1;
            end else begin
              latch   = 1'b1;
              state_d = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          mem_a   = {s_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_we  = 1'b1;
          mem_wd  = merged;
          accept  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign req0_ready = accept & ~sel;
  assign req1_ready = accept &  sel;

  // State, arbitration history, merge buffer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      merge_q     <= 32'h0;
      req0_rvalid <= 1'b0;
      req0_rdata  <= 32'h0;
      req0_err    <= 1'b0;
      req1_rvalid <= 1'b0;
      req1_rdata  <= 32'h0;
      req1_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) last_q <= sel;
      if (latch) begin
        merge_q <= mem_rd;
        owner_q <= sel;
      end
      req0_rvalid <= accept & ~sel;
      req0_rdata  <= (accept && !sel) ? rsp_data_c : 32'h0;
      req0_err    <= accept & ~sel & mis;
      req1_rvalid <= accept & sel;
      req1_rdata  <= (accept && sel) ? rsp_data_c : 32'h0;
      req1_err    <= accept & sel & mis;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a word memory sits on the mem_* port.
// Expected values come from a byte-addressed reference memory.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_we, req0_rvalid, req0_err;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_rvalid, req1_err;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [16];
  logic [7:0]  ref_b [64];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  dmem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_size(req0_size),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_size(req1_size),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_a[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  // Runs one request to completion and checks latency, response and memory.
  task automatic do_req(input bit p, input bit we, input logic [1:0] sz, input logic [5:0] a,
                        input logic [31:0] wd);
    bit          misal, got, saw_we;
    int          cyc, exp_lat, nb, wa;
    logic [31:0] exp_d;
    misal = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    wa    = int'(a) & ~3;
    exp_d = 32'h0;
    if (!misal && !we)
      for (int i = 0; i < nb; i++) exp_d = exp_d | (32'(ref_b[int'(a) + i]) << (8 * i));
    exp_lat = (we && nb < 4 && !misal) ? 1 : 0;
    if (p) begin
      req1_we = we; req1_size = sz; req1_addr = 32'(a); req1_wdata = wd; req1_valid = 1'b1;
    end else begin
      req0_we = we; req0_size = sz; req0_addr = 32'(a); req0_wdata = wd; req0_valid = 1'b1;
    end
    got = 0; cyc = 0; saw_we = 0;
    while (!got && cyc < 6) begin
      @(negedge clk);
      if (mem_we) saw_we = 1;
      if (p ? req1_ready : req0_ready) got = 1;
      else cyc++;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("accepted", 32'(got), 32'd1);
    check("accept_latency", 32'(cyc), 32'(exp_lat));
    check("rvalid", 32'(p ? req1_rvalid : req0_rvalid), 32'd1);
    check("rdata", p ? req1_rdata : req0_rdata, exp_d);
    check("err", 32'(p ? req1_err : req0_err), 32'(misal));
    if (misal) check("misaligned_no_write", 32'(saw_we), 32'd0);
    if (we && !misal)
      for (int i = 0; i < nb; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
    if (we) check("mem_word", mem[a[5:2]], ref_word(wa));
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_we = 0; req0_size = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_size = 0; req1_addr = 0; req1_wdata = 0;
    #12;
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_rvalid0", 32'(req0_rvalid), 0);
    check("rst_rvalid1", 32'(req1_rvalid), 0);
    check("rst_rdata0", req0_rdata, 0);
    check("rst_err1", 32'(req1_err), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wd", mem_wd, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the memory with known words.
    for (int w = 0; w < 16; w++) do_req(w[0], 1'b1, 2'd2, 6'(w * 4), $urandom);

    // Word store then word load.
    do_req(0, 1, 2'd2, 6'd0, 32'hDEADBEEF);
    do_req(0, 0, 2'd2, 6'd0, 32'h0);
    // Byte RMW and byte load.
    do_req(0, 1, 2'd2, 6'd8, 32'h12345678);
    do_req(0, 1, 2'd0, 6'd9, 32'h000000AB);
    check("byte_rmw_word", mem[2], 32'h1234AB78);
    do_req(0, 0, 2'd0, 6'd10, 32'h0);
    // Half RMW and half load.
    do_req(0, 1, 2'd2, 6'd4, 32'hCAFEBABE);
    do_req(0, 1, 2'd1, 6'd6, 32'h0000BEEF);
    check("half_rmw_word", mem[1], 32'hBEEFBABE);
    do_req(0, 0, 2'd1, 6'd6, 32'h0);
    // Misaligned accesses.
    do_req(0, 1, 2'd1, 6'd5, 32'h00001111);
    check("misaligned_unchanged", mem[1], 32'hBEEFBABE);
    do_req(1, 0, 2'd2, 6'd9, 32'h0);

    // Contention straight after reset alternates starting with requester 0.
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    req0_we = 0; req0_size = 2'd2; req0_addr = 32'd0; req0_valid = 1;
    req1_we = 0; req1_size = 2'd2; req1_addr = 32'd4; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      check("rr_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;

    // Requester 1 byte RMW holds off requester 0 until it completes.
    req1_we = 1; req1_size = 2'd0; req1_addr = 32'd17; req1_wdata = 32'h55; req1_valid = 1;
    @(negedge clk);
    check("rmw_idle_ready1", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_we = 0; req0_size = 2'd2; req0_addr = 32'd16; req0_valid = 1;
    @(negedge clk);
    check("rmw_wr_ready1", 32'(req1_ready), 1);
    check("rmw_wr_ready0", 32'(req0_ready), 0);
    check("rmw_wr_mem_we", 32'(mem_we), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    ref_b[17] = 8'h55;
    check("rmw_rvalid1", 32'(req1_rvalid), 1);
    @(negedge clk);
    check("stalled_ready0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0;
    check("stalled_rvalid0", 32'(req0_rvalid), 1);
    check("stalled_rdata0", req0_rdata, ref_word(16));

    // Reset in RMW_WR aborts the write.
    req0_we = 1; req0_size = 2'd0; req0_addr = 32'd22; req0_wdata = 32'h99; req0_valid = 1;
    @(negedge clk);
    check("rst_rmw_idle_ready0", 32'(req0_ready), 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_rmw_mem_we", 32'(mem_we), 0);
    check("rst_rmw_ready0", 32'(req0_ready), 0);
    check("rst_rmw_mem_a", mem_a, 0);
    check("rst_rmw_mem_wd", mem_wd, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    check("rst_rmw_no_write", mem[5], ref_word(20));
    check("rst_rmw_no_rvalid", 32'(req0_rvalid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    req0_we = 0; req0_size = 2'd2; req0_addr = 32'd20; req0_valid = 1;
    req1_we = 0; req1_size = 2'd2; req1_addr = 32'd24; req1_valid = 1;
    @(negedge clk);
    check("post_rst_ready0", 32'(req0_ready), 1);
    check("post_rst_ready1", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    check("post_rst_ready1_next", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); #1;

    // Random single-requester traffic against the byte model.
    for (int n = 0; n < 60; n++)
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             6'($urandom_range(0, 63)), $urandom);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
